multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/cpu_pkg.sv | 48 ++++
 rtl/instr_decoder.sv | 53 +++++
 rtl/multicycle_control_unit.sv | 172 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and encodings for the multicycle control unit
// Purpose: datapath width, opcode/func constants, FSM state and mux-select encodings,
//          and the instruction classes produced by instr_decoder.
// Ports: none (package).
package cpu_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  typedef enum logic [1:0] {PC_NEXT, PC_BRANCH, PC_TARGET, PC_RS} pc_src_t;

  typedef enum logic [1:0] {IMM_SIGN, IMM_LHI, IMM_TARGET, IMM_RSVD} imm_sel_t;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC, WB_RSVD} wb_sel_t;

  typedef enum logic [3:0] {
    CLS_NOP, CLS_ALU_R, CLS_ALU_I, CLS_BRANCH, CLS_JUMP,
    CLS_LINK, CLS_LOAD, CLS_STORE, CLS_WWD, CLS_HALT
  } instr_class_t;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode/func to instruction-class decoder
// Purpose: classifies the IR so the FSM only needs to branch on a class, and supplies
//          the opcode-dependent immediate select and jump target source.
// Ports: opcode[3:0], func[5:0] in; instr_class, jump_src, imm_sel out.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0]   opcode,
  input  logic [5:0]   func,
  output instr_class_t instr_class,
  output pc_src_t      jump_src,
  output imm_sel_t     imm_sel
);

  always_comb begin
    instr_class = CLS_NOP;
    jump_src    = PC_TARGET;
    imm_sel     = IMM_SIGN;
    case (opcode)
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: instr_class = CLS_BRANCH;
      OP_ADI, OP_ORI:                 instr_class = CLS_ALU_I;
      OP_LHI: begin
        instr_class = CLS_ALU_I;
        imm_sel     = IMM_LHI;
      end
      OP_LWD: instr_class = CLS_LOAD;
      OP_SWD: instr_class = CLS_STORE;
      OP_JMP: begin
        instr_class = CLS_JUMP;
        imm_sel     = IMM_TARGET;
      end
      OP_JAL: begin
        instr_class = CLS_LINK;
        imm_sel     = IMM_TARGET;
      end
      OP_RTYPE: begin
        // Register-form jumps take their target from rs.
        jump_src = PC_RS;
        case (func)
          FN_ADD, FN_SUB, FN_AND, FN_ORR,
          FN_NOT, FN_TCP, FN_SHL, FN_SHR: instr_class = CLS_ALU_R;
          FN_JPR:  instr_class = CLS_JUMP;
          FN_JRL:  instr_class = CLS_LINK;
          FN_WWD:  instr_class = CLS_WWD;
          FN_HLT:  instr_class = CLS_HALT;
          default: instr_class = CLS_NOP;
        endcase
      end
      default: instr_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - IF/ID/EX/MEM/WB/HALT control FSM for a multicycle CPU
// Purpose: sequences fetch, decode, execute, memory and write-back, driving datapath
//          selects and memory handshakes. Optional macro INSTR_COUNT_EN adds num_inst,
//          a count of instructions leaving ID.
// Ports: clk, reset_n (async, active-low); instr (IR), inputReady, ackOutput, zero_cond in;
//        readM, writeM, i_or_d, ir_write, pc_write, pc_write_cond, pc_src, imm_sel,
//        alu_src_b, reg_write, wb_sel, wwd_valid, is_halted out; num_inst (INSTR_COUNT_EN).
module multicycle_control_unit
  import cpu_pkg::*;
#(
  parameter int WORD_SIZE = cpu_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  input  logic                 zero_cond,
  output logic                 readM,
  output logic                 writeM,
  output logic                 i_or_d,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_src,
  output logic [1:0]           imm_sel,
  output logic                 alu_src_b,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 wwd_valid,
  output logic                 is_halted
`ifdef INSTR_COUNT_EN
  ,
  output logic [WORD_SIZE-1:0] num_inst
`endif
);

  state_t       state, state_next;
  logic         running;
  instr_class_t dec_class;
  pc_src_t      dec_jump;
  imm_sel_t     dec_imm;
  logic         unused_bits;

  // Register fields are consumed by the datapath, not by control.
  assign unused_bits = ^{instr[11:6], zero_cond};

  instr_decoder u_decoder (
    .opcode      (instr[15:12]),
    .func        (instr[5:0]),
    .instr_class (dec_class),
    .jump_src    (dec_jump),
    .imm_sel     (dec_imm)
  );

  // running stays low until the first clock edge after reset release, so the
  // first fetch request appears on that edge rather than at reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IF;
      running <= 1'b0;
    end else begin
      state   <= state_next;
      running <= 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    readM         = 1'b0;
    writeM        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_NEXT;
    imm_sel       = IMM_SIGN;
    alu_src_b     = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = WB_ALU;
    wwd_valid     = 1'b0;
    is_halted     = 1'b0;
    if (running) begin
      case (state)
        S_IF: begin
          readM = 1'b1;
          if (inputReady) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = S_ID;
          end
        end
        S_ID: begin
          imm_sel = dec_imm;
          case (dec_class)
            CLS_HALT: state_next = S_HALT;
            CLS_NOP:  state_next = S_IF;
            default:  state_next = S_EX;
          endcase
        end
        S_EX: begin
          imm_sel    = dec_imm;
          state_next = S_IF;
          case (dec_class)
            CLS_ALU_R: state_next = S_WB;
            CLS_ALU_I: begin
              alu_src_b  = 1'b1;
              state_next = S_WB;
            end
            CLS_BRANCH: begin
              pc_write_cond = 1'b1;
              pc_src        = PC_BRANCH;
            end
            CLS_JUMP: begin
              pc_write = 1'b1;
              pc_src   = dec_jump;
            end
            CLS_LINK: begin
              pc_write   = 1'b1;
              pc_src     = dec_jump;
              state_next = S_WB;
            end
            CLS_LOAD, CLS_STORE: begin
              alu_src_b  = 1'b1;
              imm_sel    = IMM_SIGN;
              state_next = S_MEM;
            end
            CLS_WWD: wwd_valid = 1'b1;
            default: state_next = S_IF;
          endcase
        end
        S_MEM: begin
          // Address operands are held so the data address stays stable while waiting.
          i_or_d    = 1'b1;
          alu_src_b = 1'b1;
          if (dec_class == CLS_LOAD) begin
            readM = 1'b1;
            if (inputReady) state_next = S_WB;
          end else if (dec_class == CLS_STORE) begin
            writeM = 1'b1;
            if (ackOutput) state_next = S_IF;
          end else begin
            i_or_d     = 1'b0;
            state_next = S_IF;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          state_next = S_IF;
          case (dec_class)
            CLS_LOAD: wb_sel = WB_MEM;
            CLS_LINK: wb_sel = WB_PC;
            default:  wb_sel = WB_ALU;
          endcase
        end
        S_HALT: is_halted = 1'b1;
        default: state_next = S_IF;
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_inst <= '0;
    end else if (state == S_ID) begin
      num_inst <= num_inst + WORD_SIZE'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        inputReady = 1'b0;
  logic        ackOutput = 1'b0;
  logic        zero_cond = 1'b0;
  logic        readM, writeM, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src, imm_sel, wb_sel;
  logic        alu_src_b, reg_write, wwd_valid, is_halted;
`ifdef INSTR_COUNT_EN
  logic [15:0] num_inst;
`endif
  logic [15:0] outs;

  int errors = 0;
  int checks = 0;
  int exp_count = 0;

  // Observations gathered per instruction by run_instr.
  int   o_cycles, o_fetch_rd, o_irw, o_irw_cyc, o_mem_rd, o_wr, o_regw, o_regw_cyc;
  int   o_pcj, o_pcc, o_wwd, o_both;
  int   o_wbsel, o_jsrc, o_csrc, o_imm, o_alub;
  bit   o_halted;

  typedef struct {
    bit ex; bit rd; bit wr; bit wb; int wbv; bit has_alu; bit alub;
    int imm; int jmp; bit br; bit wwd; bit halt;
  } exp_t;

  multicycle_control_unit #(.WORD_SIZE(16)) dut (
`ifdef INSTR_COUNT_EN
    .num_inst      (num_inst),
`endif
    .clk           (clk),
    .reset_n       (reset_n),
    .instr         (instr),
    .inputReady    (inputReady),
    .ackOutput     (ackOutput),
    .zero_cond     (zero_cond),
    .readM         (readM),
    .writeM        (writeM),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .imm_sel       (imm_sel),
    .alu_src_b     (alu_src_b),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .wwd_valid     (wwd_valid),
    .is_halted     (is_halted)
  );

  assign outs = {readM, writeM, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                 imm_sel, alu_src_b, reg_write, wb_sel, wwd_valid, is_halted};

  always #5 clk = ~clk;

  // Behaviour an instruction should exhibit, taken from the ISA description.
  function automatic exp_t model(input logic [15:0] ins);
    exp_t e;
    int op, fn;
    e = '{default: 0};
    op = int'(ins[15:12]);
    fn = int'(ins[5:0]);
    if (op <= 3) begin
      e.ex = 1; e.br = 1;
    end else if (op >= 4 && op <= 6) begin
      e.ex = 1; e.wb = 1; e.has_alu = 1; e.alub = 1; e.imm = (op == 6) ? 1 : 0;
    end else if (op == 7) begin
      e.ex = 1; e.rd = 1; e.wb = 1; e.wbv = 1; e.has_alu = 1; e.alub = 1;
    end else if (op == 8) begin
      e.ex = 1; e.wr = 1; e.has_alu = 1; e.alub = 1;
    end else if (op == 9) begin
      e.ex = 1; e.jmp = 2; e.imm = 2;
    end else if (op == 10) begin
      e.ex = 1; e.jmp = 2; e.imm = 2; e.wb = 1; e.wbv = 2;
    end else if (op == 15) begin
      if (fn <= 7) begin
        e.ex = 1; e.wb = 1; e.has_alu = 1; e.alub = 0;
      end else if (fn == 25) begin
        e.ex = 1; e.jmp = 3;
      end else if (fn == 26) begin
        e.ex = 1; e.jmp = 3; e.wb = 1; e.wbv = 2;
      end else if (fn == 28) begin
        e.ex = 1; e.wwd = 1;
      end else if (fn == 29) begin
        e.halt = 1;
      end
    end
    return e;
  endfunction

  function automatic int exp_cycles(input exp_t e, input int fw, input int mw);
    int n;
    n = fw + 2;
    if (e.ex) n = n + 1;
    if (e.rd || e.wr) n = n + mw + 1;
    if (e.wb) n = n + 1;
    return n;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    #1;
  endtask

  task automatic do_reset;
    reset_n = 1'b0; inputReady = 1'b0; ackOutput = 1'b0; zero_cond = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    exp_count = 0;
    tick();
  endtask

  // Plays the memory for one instruction from its first IF cycle until the next
  // fetch begins (or HALT is reached), recording what the control unit did.
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw, input logic zc);
    int cyc, fcnt, mcnt;
    bit fetched;
    instr = ins; zero_cond = zc;
    cyc = 0; fcnt = 0; mcnt = 0; fetched = 0;
    o_fetch_rd = 0; o_irw = 0; o_irw_cyc = -10; o_mem_rd = 0; o_wr = 0; o_regw = 0;
    o_regw_cyc = -1; o_pcj = 0; o_pcc = 0; o_wwd = 0; o_both = 0; o_wbsel = -1;
    o_jsrc = -1; o_csrc = -1; o_imm = -1; o_alub = -1; o_halted = 0;
    forever begin
      if (cyc > 200) begin
        errors++; checks++;
        $display("FAIL run_budget ins=%h stuck after %0d cycles", ins, cyc);
        break;
      end
      if (is_halted) begin
        o_halted = 1;
        break;
      end
      if (readM && !i_or_d) begin
        if (fetched) break;
        if (fcnt == fw) inputReady = 1'b1;
        fcnt++; o_fetch_rd++;
      end else if (readM && i_or_d) begin
        if (mcnt == mw) inputReady = 1'b1;
        mcnt++; o_mem_rd++;
      end else if (writeM) begin
        if (mcnt == mw) ackOutput = 1'b1;
        mcnt++; o_wr++;
      end
      #1;
      if (readM && writeM) o_both++;
      if (ir_write) begin fetched = 1; o_irw++; o_irw_cyc = cyc; end
      if (reg_write) begin o_regw++; o_wbsel = int'(wb_sel); o_regw_cyc = cyc; end
      if (pc_write && !ir_write) begin o_pcj++; o_jsrc = int'(pc_src); end
      if (pc_write_cond) begin o_pcc++; o_csrc = int'(pc_src); end
      if (wwd_valid) o_wwd++;
      if (cyc == o_irw_cyc + 1) o_imm = int'(imm_sel);
      if (cyc == o_irw_cyc + 2) o_alub = int'(alu_src_b);
      tick();
      cyc++;
    end
    o_cycles = cyc;
    exp_count++;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (outs !== 16'h0000) begin errors++; $display("FAIL reset_outputs got %h exp 0000", outs); end
    reset_n = 1'b1;
    #1;
    checks++;
    if (readM !== 1'b0) begin errors++; $display("FAIL reset_release_no_edge readM got %b exp 0", readM); end
    exp_count = 0;
    tick();
    checks++;
    if (readM !== 1'b1 || i_or_d !== 1'b0) begin
      errors++; $display("FAIL first_fetch readM=%b i_or_d=%b exp 1 0", readM, i_or_d);
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (num_inst !== 16'd0) begin errors++; $display("FAIL num_inst_reset got %0d exp 0", num_inst); end
`endif
  endtask

  task automatic test_adi;
    run_instr(16'h4105, 3, 0, 1'b0);
    checks++;
    if (o_fetch_rd !== 4) begin errors++; $display("FAIL adi_readM_cycles got %0d exp 4", o_fetch_rd); end
    checks++;
    if (o_irw !== 1 || o_irw_cyc !== 3) begin
      errors++; $display("FAIL adi_ir_write count=%0d at=%0d exp 1 at 3", o_irw, o_irw_cyc);
    end
    checks++;
    if (o_regw !== 1 || o_regw_cyc - o_irw_cyc !== 3) begin
      errors++; $display("FAIL adi_reg_write count=%0d delay=%0d exp 1 delay 3", o_regw, o_regw_cyc - o_irw_cyc);
    end
    checks++;
    if (o_alub !== 1 || o_imm !== 0) begin
      errors++; $display("FAIL adi_selects alu_src_b=%0d imm_sel=%0d exp 1 0", o_alub, o_imm);
    end
  endtask

  task automatic test_lwd;
    run_instr(16'h7104, 0, 2, 1'b0);
    checks++;
    if (o_mem_rd !== 3) begin errors++; $display("FAIL lwd_mem_read_cycles got %0d exp 3", o_mem_rd); end
    checks++;
    if (o_regw !== 1 || o_wbsel !== 1) begin
      errors++; $display("FAIL lwd_writeback count=%0d wb_sel=%0d exp 1 1", o_regw, o_wbsel);
    end
    checks++;
    if (o_cycles !== 7) begin errors++; $display("FAIL lwd_cycles got %0d exp 7", o_cycles); end
  endtask

  task automatic test_swd;
    run_instr(16'h8104, 0, 4, 1'b0);
    checks++;
    if (o_wr !== 5) begin errors++; $display("FAIL swd_writeM_cycles got %0d exp 5", o_wr); end
    checks++;
    if (o_mem_rd !== 0 || o_both !== 0) begin
      errors++; $display("FAIL swd_readM mem_reads=%0d overlap=%0d exp 0 0", o_mem_rd, o_both);
    end
    checks++;
    if (o_regw !== 0) begin errors++; $display("FAIL swd_reg_write got %0d exp 0", o_regw); end
    checks++;
    if (o_cycles !== 8) begin errors++; $display("FAIL swd_cycles got %0d exp 8", o_cycles); end
  endtask

  task automatic test_branch;
    for (int z = 1; z >= 0; z--) begin
      run_instr(16'h1102, 1, 0, z[0]);
      checks++;
      if (o_pcc !== 1 || o_csrc !== 1) begin
        errors++; $display("FAIL beq_zc%0d pc_write_cond=%0d pc_src=%0d exp 1 1", z, o_pcc, o_csrc);
      end
      checks++;
      if (o_cycles !== 4 || o_regw !== 0) begin
        errors++; $display("FAIL beq_zc%0d_return cycles=%0d reg_write=%0d exp 4 0", z, o_cycles, o_regw);
      end
    end
  endtask

  task automatic test_random;
    int fns[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 25, 26, 28, 40};
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ins;
      logic [3:0]  op;
      logic [5:0]  fn;
      exp_t e;
      int fw, mw;
      op = 4'($urandom_range(0, 15));
      fn = (op == 4'd15) ? 6'(fns[$urandom_range(0, 11)]) : 6'($urandom);
      ins = {op, 6'($urandom), fn};
      fw = $urandom_range(0, 3);
      mw = $urandom_range(0, 3);
      e = model(ins);
      run_instr(ins, fw, mw, 1'($urandom));
      checks++;
      if (o_cycles !== exp_cycles(e, fw, mw) || o_irw !== 1 || o_fetch_rd !== fw + 1) begin
        errors++;
        $display("FAIL rand_timing ins=%h cycles=%0d irw=%0d fetch=%0d exp %0d 1 %0d",
                 ins, o_cycles, o_irw, o_fetch_rd, exp_cycles(e, fw, mw), fw + 1);
      end
      checks++;
      if (o_mem_rd !== (e.rd ? mw + 1 : 0) || o_wr !== (e.wr ? mw + 1 : 0) || o_both !== 0) begin
        errors++;
        $display("FAIL rand_memory ins=%h rd=%0d wr=%0d overlap=%0d exp %0d %0d 0",
                 ins, o_mem_rd, o_wr, o_both, e.rd ? mw + 1 : 0, e.wr ? mw + 1 : 0);
      end
      checks++;
      if (o_regw !== int'(e.wb) || (e.wb && o_wbsel !== e.wbv)) begin
        errors++; $display("FAIL rand_writeback ins=%h reg_write=%0d wb_sel=%0d exp %0d %0d",
                           ins, o_regw, o_wbsel, e.wb, e.wbv);
      end
      checks++;
      if (o_pcj !== (e.jmp != 0 ? 1 : 0) || (e.jmp != 0 && o_jsrc !== e.jmp)) begin
        errors++; $display("FAIL rand_jump ins=%h pc_write=%0d pc_src=%0d exp %0d %0d",
                           ins, o_pcj, o_jsrc, e.jmp != 0, e.jmp);
      end
      checks++;
      if (o_pcc !== int'(e.br) || (e.br && o_csrc !== 1) || o_wwd !== int'(e.wwd)) begin
        errors++; $display("FAIL rand_branch_wwd ins=%h cond=%0d src=%0d wwd=%0d exp %0d 1 %0d",
                           ins, o_pcc, o_csrc, o_wwd, e.br, e.wwd);
      end
      if (e.has_alu) begin
        checks++;
        if (o_alub !== int'(e.alub)) begin
          errors++; $display("FAIL rand_alu_src_b ins=%h got %0d exp %0d", ins, o_alub, e.alub);
        end
      end
      if (e.ex && op != 4'd15) begin
        checks++;
        if (o_imm !== e.imm) begin
          errors++; $display("FAIL rand_imm_sel ins=%h got %0d exp %0d", ins, o_imm, e.imm);
        end
      end
    end
  endtask

  task automatic test_halt;
    int bad;
    logic [15:0] cnt_at_halt;
    do_reset();
    run_instr(16'h4105, 0, 0, 1'b0);
    run_instr(16'h7104, 1, 1, 1'b0);
    run_instr(16'h1102, 0, 0, 1'b1);
    run_instr(16'hF01D, 0, 0, 1'b0);
    checks++;
    if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_reached got %0d exp 1", o_halted); end
`ifdef INSTR_COUNT_EN
    cnt_at_halt = num_inst;
    checks++;
    if (num_inst !== 16'(exp_count)) begin
      errors++; $display("FAIL num_inst_after_halt got %0d exp %0d", num_inst, exp_count);
    end
`else
    cnt_at_halt = 16'd0;
`endif
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!is_halted || readM || writeM || ir_write || pc_write || pc_write_cond ||
          reg_write || wwd_valid) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL halt_hold bad_cycles=%0d exp 0", bad); end
`ifdef INSTR_COUNT_EN
    checks++;
    if (num_inst !== cnt_at_halt) begin
      errors++; $display("FAIL num_inst_stable got %0d exp %0d", num_inst, cnt_at_halt);
    end
`else
    if (cnt_at_halt != 16'd0) $display("note: unexpected counter value");
`endif
  endtask

  task automatic test_async_reset;
    do_reset();
    tick();
    checks++;
    if (readM !== 1'b1) begin errors++; $display("FAIL midfetch_readM got %b exp 1", readM); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (readM !== 1'b0 || outs !== 16'h0000) begin
      errors++; $display("FAIL async_reset readM=%b outs=%h exp 0 0000", readM, outs);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_adi();
    test_lwd();
    test_swd();
    test_branch();
    test_random();
    test_halt();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
